// File: rtl/debug_dump_sender.sv
// Streams a padded register snapshot followed by a block of memory words out over a byte-wide UART handshake.
// Optional trailing XOR checksum byte is built when DEBUG_DUMP_CSUM_EN is defined.
module debug_dump_sender #(
    parameter int UART_BITS   = 8,
    parameter int SNAP_BITS   = 1000,
    parameter int WORD_BITS   = 32,
    parameter int ADDR_BITS   = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [SNAP_BITS-1:0] i_snapshot,
    input  logic [ADDR_BITS-1:0] i_mem_base,
    input  logic [ADDR_BITS:0]   i_mem_count,
    input  logic                 i_msb_first,
    input  logic                 i_tx_ready,
    input  logic [WORD_BITS-1:0] i_mem_data,
    output logic                 o_mem_rd_en,
    output logic [ADDR_BITS-1:0] o_mem_rd_addr,
    output logic                 o_tx_start,
    output logic [UART_BITS-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int SNAP_BYTES = (SNAP_BITS + UART_BITS - 1) / UART_BITS;
    localparam int PAD_BITS   = SNAP_BYTES * UART_BITS;
    localparam int BPW        = WORD_BITS / UART_BITS;
    localparam int SCW        = $clog2(SNAP_BYTES + 1);
    localparam int BCW        = $clog2(BPW + 1);
    localparam int LCW        = 3;

    typedef enum logic [3:0] {
        IDLE, SNAP_WAIT, SNAP_SEND, MEM_REQ, MEM_WAIT, MEM_LOAD, BYTE_WAIT, BYTE_SEND,
`ifdef DEBUG_DUMP_CSUM_EN
        TRAIL_WAIT, TRAIL_SEND,
`endif
        DRAIN, DONE
    } state_t;

    state_t                r_state, w_next, w_after_data;
    logic [PAD_BITS-1:0]   r_snap, w_pad;
    logic [SCW-1:0]        r_snap_left;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS:0]    r_words_left;
    logic                  r_msb;
    logic [WORD_BITS-1:0]  r_word;
    logic [BCW-1:0]        r_byte_left;
    logic [LCW-1:0]        r_lat_cnt;
    logic                  r_guard;
    logic                  w_rdy;
    logic [UART_BITS-1:0]  w_word_byte;
`ifdef DEBUG_DUMP_CSUM_EN
    logic [UART_BITS-1:0]  r_csum;
`endif

    // Unused low bits of the last snapshot byte are filled with 1s.
    always_comb begin
        w_pad = '1;
        w_pad[PAD_BITS-1 -: SNAP_BITS] = i_snapshot;
    end

    assign w_word_byte = r_msb ? r_word[WORD_BITS-1 -: UART_BITS] : r_word[UART_BITS-1:0];
    // The UART may take a cycle to drop ready after a send, so skip the first sample.
    assign w_rdy = i_tx_ready & ~r_guard;

    always_comb begin
`ifdef DEBUG_DUMP_CSUM_EN
        w_after_data = TRAIL_WAIT;
`else
        w_after_data = DRAIN;
`endif
        w_next        = r_state;
        o_mem_rd_en   = 1'b0;
        o_mem_rd_addr = '0;
        o_tx_start    = 1'b0;
        o_tx_data     = '0;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = SNAP_WAIT;
            end
            SNAP_WAIT: if (w_rdy) w_next = SNAP_SEND;
            SNAP_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = r_snap[PAD_BITS-1 -: UART_BITS];
                if (r_snap_left == SCW'(1))
                    w_next = (r_words_left == '0) ? w_after_data : MEM_REQ;
                else
                    w_next = SNAP_WAIT;
            end
            MEM_REQ: begin
                o_mem_rd_en   = 1'b1;
                o_mem_rd_addr = r_addr;
                w_next        = (MEM_LATENCY > 1) ? MEM_WAIT : MEM_LOAD;
            end
            MEM_WAIT: if (r_lat_cnt == LCW'(MEM_LATENCY - 2)) w_next = MEM_LOAD;
            MEM_LOAD:  w_next = BYTE_WAIT;
            BYTE_WAIT: if (w_rdy) w_next = BYTE_SEND;
            BYTE_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = w_word_byte;
                if (r_byte_left == BCW'(1))
                    w_next = (r_words_left == '0) ? w_after_data : MEM_REQ;
                else
                    w_next = BYTE_WAIT;
            end
`ifdef DEBUG_DUMP_CSUM_EN
            TRAIL_WAIT: if (w_rdy) w_next = TRAIL_SEND;
            TRAIL_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = r_csum;
                w_next     = DRAIN;
            end
`endif
            DRAIN: if (w_rdy) w_next = DONE;
            DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_snap       <= '0;
            r_snap_left  <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_msb        <= 1'b0;
            r_word       <= '0;
            r_byte_left  <= '0;
            r_lat_cnt    <= '0;
            r_guard      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_guard <= o_tx_start;
            case (r_state)
                IDLE: if (i_start) begin
                    r_snap       <= w_pad;
                    r_snap_left  <= SCW'(SNAP_BYTES);
                    r_addr       <= i_mem_base;
                    r_words_left <= i_mem_count;
                    r_msb        <= i_msb_first;
                end
                SNAP_SEND: begin
                    r_snap      <= r_snap << UART_BITS;
                    r_snap_left <= r_snap_left - SCW'(1);
                end
                MEM_REQ:  r_lat_cnt <= '0;
                MEM_WAIT: r_lat_cnt <= r_lat_cnt + LCW'(1);
                MEM_LOAD: begin
                    r_word       <= i_mem_data;
                    r_byte_left  <= BCW'(BPW);
                    r_words_left <= r_words_left - 1'b1;
                    r_addr       <= r_addr + 1'b1;
                end
                BYTE_SEND: begin
                    r_word      <= r_msb ? (r_word << UART_BITS) : (r_word >> UART_BITS);
                    r_byte_left <= r_byte_left - BCW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef DEBUG_DUMP_CSUM_EN
    always_ff @(posedge clk) begin
        if (!rst)
            r_csum <= '0;
        else if (r_state == IDLE && i_start)
            r_csum <= '0;
        else if (o_tx_start)
            r_csum <= r_csum ^ o_tx_data;
    end
`endif

endmodule

// File: tb/tb_debug_dump_sender.sv
// Bench for debug_dump_sender: directed table, hold-off/ignore and reset sequences, randomized dumps vs a byte-list model.
module tb_debug_dump_sender;
    localparam int UB = 8, SB = 20, WB = 32, AB = 10, LAT = 3;
    localparam int NSB = (SB + UB - 1) / UB;
    localparam int PAD = NSB * UB;
    localparam int BPW = WB / UB;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [SB-1:0] i_snapshot = '0;
    logic [AB-1:0] i_mem_base = '0;
    logic [AB:0]   i_mem_count = '0;
    logic          i_msb_first = 1'b0;
    logic          i_tx_ready;
    logic [WB-1:0] i_mem_data;
    logic          o_mem_rd_en, o_tx_start, o_busy, o_done;
    logic [AB-1:0] o_mem_rd_addr;
    logic [UB-1:0] o_tx_data;

    always #5 clk = ~clk;

    debug_dump_sender #(.UART_BITS(UB), .SNAP_BITS(SB), .WORD_BITS(WB), .ADDR_BITS(AB), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_snapshot(i_snapshot), .i_mem_base(i_mem_base),
        .i_mem_count(i_mem_count), .i_msb_first(i_msb_first), .i_tx_ready(i_tx_ready),
        .i_mem_data(i_mem_data), .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done));

    // Memory returns data only in the exact cycle LAT after a request; any other cycle gives junk.
    logic [WB-1:0] mem [DEPTH];
    logic [LAT-1:0] pv = '0;
    logic [AB-1:0]  pa [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], o_mem_rd_en};
        pa[0] <= o_mem_rd_addr;
        for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
    end
    assign i_mem_data = pv[LAT-1] ? mem[pa[LAT-1]] : 32'h5A5A_A5A5;

    // UART: busy for a random few cycles after every send; tx_hold forces ready low.
    int tx_cnt = 0;
    bit tx_hold = 1'b0;
    assign i_tx_ready = (tx_cnt == 0) && !tx_hold;
    always @(posedge clk) begin
        if (o_tx_start) tx_cnt <= 1 + int'($urandom_range(0, 3));
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end

    logic [UB-1:0] got_q[$];
    logic [AB-1:0] rd_q[$];
    int done_cnt = 0, glitch_cnt = 0;
    always @(negedge clk) begin
        if (o_tx_start) got_q.push_back(o_tx_data);
        else if (o_tx_data != '0) glitch_cnt++;
        if (o_mem_rd_en) rd_q.push_back(o_mem_rd_addr);
        else if (o_mem_rd_addr != '0) glitch_cnt++;
        if (o_done) begin
            done_cnt++;
            if (o_busy) glitch_cnt++;
        end
    end

    int n_checks = 0, n_errors = 0;
    logic [UB-1:0] exp_q[$];
    int b0, r0, d0, g0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: padded snapshot split MSB byte first, then each word split per byte order, then XOR trailer.
    task automatic build_model(input logic [SB-1:0] snap, input int base, input int cnt, input bit msb);
        longint p;
        logic [WB-1:0] w;
        int sh;
        exp_q.delete();
        p = longint'(snap) * (64'd1 << (PAD - SB)) + ((64'd1 << (PAD - SB)) - 1);
        for (int i = 0; i < NSB; i++) exp_q.push_back(UB'((p >> (UB * (NSB - 1 - i))) & 255));
        for (int j = 0; j < cnt; j++) begin
            w = mem[(base + j) % DEPTH];
            for (int b = 0; b < BPW; b++) begin
                sh = msb ? (BPW - 1 - b) : b;
                exp_q.push_back(UB'((w >> (UB * sh)) & 255));
            end
        end
    endtask

    task automatic add_trailer();
`ifdef DEBUG_DUMP_CSUM_EN
        logic [UB-1:0] x = '0;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic start_dump(input logic [SB-1:0] snap, input int base, input int cnt, input bit msb);
        b0 = got_q.size(); r0 = rd_q.size(); d0 = done_cnt; g0 = glitch_cnt;
        @(negedge clk);
        i_start = 1'b1; i_snapshot = snap; i_mem_base = AB'(base);
        i_mem_count = (AB+1)'(cnt); i_msb_first = msb;
        @(negedge clk);
        i_start = 1'b0;
        // Scramble inputs: the dump must use only what was latched.
        i_snapshot = SB'($urandom); i_mem_base = AB'($urandom);
        i_mem_count = (AB+1)'($urandom); i_msb_first = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk({tag, " done pulses"}, longint'(done_cnt - d0), 1);
        chk({tag, " idle after"}, longint'(o_busy), 0);
    endtask

    task automatic compare(input string tag, input int base, input int cnt);
        int nb = got_q.size() - b0;
        int nr = rd_q.size() - r0;
        chk({tag, " byte count"}, longint'(nb), longint'(exp_q.size()));
        for (int i = 0; i < nb && i < exp_q.size(); i++)
            chk($sformatf("%s byte %0d", tag, i), longint'(got_q[b0 + i]), longint'(exp_q[i]));
        chk({tag, " read count"}, longint'(nr), longint'(cnt));
        for (int j = 0; j < nr && j < cnt; j++)
            chk($sformatf("%s read %0d", tag, j), longint'(rd_q[r0 + j]), longint'((base + j) % DEPTH));
        chk({tag, " idle outputs clean"}, longint'(glitch_cnt - g0), 0);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k = 0;
        while (got_q.size() < b0 + n && k < 500) begin @(negedge clk); k++; end
        chk({tag, " reached byte"}, longint'(got_q.size() - b0), longint'(n));
    endtask

    typedef struct {
        logic [SB-1:0]     snap;
        int                base;
        int                cnt;
        bit                msb;
        int                nexp;
        logic [0:10][7:0]  exp;
    } vec_t;
    vec_t tbl[3];

    initial begin
        logic [SB-1:0] rs;
        int rb, rc;
        bit rm;
        tbl[0] = '{20'hABCDE, 0, 0, 1'b0, 3, {8'hAB, 8'hCD, 8'hEF, 64'h0}};
        tbl[1] = '{20'hABCDE, 5, 2, 1'b0, 11,
                   {8'hAB, 8'hCD, 8'hEF, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA}};
        tbl[2] = '{20'h12345, 1023, 2, 1'b1, 11,
                   {8'h12, 8'h34, 8'h5F, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h01, 8'h02, 8'h03, 8'h04}};
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[5] = 32'h1122_3344; mem[6] = 32'hAABB_CCDD;
        mem[1023] = 32'hCAFE_F00D; mem[0] = 32'h0102_0304;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", longint'(o_busy), 0);
        chk("reset tx_start", longint'(o_tx_start), 0);
        chk("reset tx_data", longint'(o_tx_data), 0);
        chk("reset rd_en", longint'(o_mem_rd_en), 0);
        chk("reset rd_addr", longint'(o_mem_rd_addr), 0);
        chk("reset done", longint'(o_done), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            exp_q.delete();
            for (int k = 0; k < tbl[v].nexp; k++) exp_q.push_back(tbl[v].exp[k]);
            add_trailer();
            start_dump(tbl[v].snap, tbl[v].base, tbl[v].cnt, tbl[v].msb);
            wait_done($sformatf("vec%0d", v), 2000);
            compare($sformatf("vec%0d", v), tbl[v].base, tbl[v].cnt);
        end

        // Ready held low before byte 2; a second start mid-dump must be ignored.
        build_model(tbl[1].snap, tbl[1].base, tbl[1].cnt, tbl[1].msb);
        add_trailer();
        start_dump(tbl[1].snap, tbl[1].base, tbl[1].cnt, tbl[1].msb);
        wait_bytes("hold", 1);
        tx_hold = 1'b1;
        @(negedge clk);
        i_start = 1'b1; i_snapshot = '0; i_mem_count = '0;
        @(negedge clk);
        i_start = 1'b0;
        repeat (50) @(negedge clk);
        chk("hold no send", longint'(got_q.size() - b0), 1);
        chk("hold busy", longint'(o_busy), 1);
        tx_hold = 1'b0;
        wait_done("hold", 2000);
        compare("hold", tbl[1].base, tbl[1].cnt);

        // Reset while parked waiting to send a memory byte.
        start_dump(tbl[1].snap, tbl[1].base, tbl[1].cnt, tbl[1].msb);
        wait_bytes("rst", NSB + 1);
        tx_hold = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst busy", longint'(o_busy), 0);
        chk("midrst tx_start", longint'(o_tx_start), 0);
        chk("midrst tx_data", longint'(o_tx_data), 0);
        chk("midrst rd_en", longint'(o_mem_rd_en), 0);
        chk("midrst rd_addr", longint'(o_mem_rd_addr), 0);
        chk("midrst done", longint'(o_done), 0);
        rst = 1'b1;
        tx_hold = 1'b0;
        b0 = got_q.size(); d0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("post-rst silent", longint'(got_q.size() - b0), 0);
        chk("post-rst no done", longint'(done_cnt - d0), 0);
        start_dump(tbl[1].snap, tbl[1].base, tbl[1].cnt, tbl[1].msb);
        wait_done("restart", 2000);
        compare("restart", tbl[1].base, tbl[1].cnt);

        for (int r = 0; r < 7; r++) begin
            rs = SB'($urandom);
            rb = int'($urandom_range(0, DEPTH - 1));
            rc = (r == 6) ? DEPTH : int'($urandom_range(0, 5));
            rm = 1'($urandom);
            if (r == 0) rb = DEPTH - 2;
            build_model(rs, rb, rc, rm);
            add_trailer();
            start_dump(rs, rb, rc, rm);
            wait_done($sformatf("rand%0d", r), (r == 6) ? 60000 : 3000);
            compare($sformatf("rand%0d", r), rb, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
